conv_feeder: RTL and testbench

Operand sequencer that drives the `conv_kern` input side (`vld_i`, `win`, `din`, `in_ch`, `is_conv3x3`). On `start` it walks every output pixel and every input-channel group. For each beat it reads one pre-assembled window word from the feature buffer and one from the weight buffer. It masks unused taps and channels, then issues a single-cycle valid beat per group. It sits between the on-chip buffers and `conv_kern`, and reports `busy`/`done` to the layer controller.

---
 rtl/conv_pkg.sv | 29 ++
 rtl/conv_feeder_if.sv | 31 +++
 rtl/operand_mask.sv | 25 ++
 rtl/conv_feeder.sv | 167 ++++++++++++++++
 tb/tb_conv_feeder.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared conv datapath definitions: operand geometry, feeder state encoding
// and the tap/channel element layout used by both conv_feeder and conv_kern.
package conv_pkg;

  localparam int unsigned WI       = 8;    // operand element width
  localparam int unsigned N        = 16;   // channels per beat
  localparam int unsigned MAC_NUM  = 9;    // taps per beat
  localparam int unsigned ADDR_W   = 12;   // buffer address width
  localparam int unsigned ELEM_NUM = MAC_NUM * N;
  localparam int unsigned OP_W     = ELEM_NUM * WI;
  localparam int unsigned TAP_W    = N * WI;
  localparam int unsigned CH_W     = 8;
  localparam int unsigned PIX_W    = 16;
  localparam int unsigned GRP_W    = $clog2(256 / N) + 1;  // holds ceil(255/N)
  localparam int unsigned REM_W    = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Element (tap t, channel c) lives at bits [elem_idx(t,c)*WI +: WI].
  function automatic int unsigned elem_idx(input int unsigned t, input int unsigned c);
    return t * N + c;
  endfunction

endpackage

// File: rtl/conv_feeder_if.sv
// Buffer read ports and conv_kern operand side of the feeder.
//   wbuf_*/dbuf_* : weight / feature buffer read (data valid 1 cycle after rd)
//   cfg_*         : captured layer configuration toward conv_kern
//   vld_o/win_o/din_o : masked operand beat toward conv_kern
interface conv_feeder_if;
  import conv_pkg::*;

  logic              wbuf_rd;
  logic [ADDR_W-1:0] wbuf_addr;
  logic [OP_W-1:0]   wbuf_data;
  logic              dbuf_rd;
  logic [ADDR_W-1:0] dbuf_addr;
  logic [OP_W-1:0]   dbuf_data;
  logic [CH_W-1:0]   cfg_in_ch;
  logic              cfg_is_conv3x3;
  logic              vld_o;
  logic [OP_W-1:0]   win_o;
  logic [OP_W-1:0]   din_o;

  modport master (
    output wbuf_rd, wbuf_addr, dbuf_rd, dbuf_addr,
    output cfg_in_ch, cfg_is_conv3x3, vld_o, win_o, din_o,
    input  wbuf_data, dbuf_data
  );

  modport slave (
    input  wbuf_rd, wbuf_addr, dbuf_rd, dbuf_addr,
    input  cfg_in_ch, cfg_is_conv3x3, vld_o, win_o, din_o,
    output wbuf_data, dbuf_data
  );
endinterface

// File: rtl/operand_mask.sv
// Per-element keep mask for one operand beat.
//   is_conv3x3_i : 0 keeps only tap 0
//   last_grp_i   : beat belongs to the last channel group
//   rem_i        : in_ch mod N; nonzero trims channels >= rem_i in last group
//   mask_c_o     : 1 = keep element, indexed by elem_idx(t,c)
module operand_mask
  import conv_pkg::*;
(
  input  logic               is_conv3x3_i,
  input  logic               last_grp_i,
  input  logic [REM_W-1:0]   rem_i,
  output logic [ELEM_NUM-1:0] mask_c_o
);

  always_comb begin
    mask_c_o = '0;
    for (int unsigned t = 0; t < MAC_NUM; t++) begin
      for (int unsigned c = 0; c < N; c++) begin
        mask_c_o[elem_idx(t, c)] = (is_conv3x3_i || (t == 0)) &&
            !(last_grp_i && (rem_i != '0) && (c >= 32'(rem_i)));
      end
    end
  end

endmodule

// File: rtl/conv_feeder.sv
// Operand sequencer: walks pixels x channel groups, reads one window word
// from each buffer per beat, masks unused taps/channels and issues one
// valid beat per group toward conv_kern.
//   clk, rstn : clock, async active-low reset
//   start     : launch pulse, sampled in IDLE only
//   in_ch, is_conv3x3, num_pix : layer configuration, captured at start
//   hold      : suppresses new buffer reads (in-flight beats still drain)
//   bus       : buffer read ports and conv_kern operand side
//   busy/done : layer status toward the controller
module conv_feeder
  import conv_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [CH_W-1:0]  in_ch,
  input  logic             is_conv3x3,
  input  logic [PIX_W-1:0] num_pix,
  input  logic             hold,
  conv_feeder_if.master    bus,
  output logic             busy,
  output logic             done
);

  state_e             state_q, state_d;
  logic [CH_W-1:0]    cfg_in_ch_q, cfg_in_ch_d;
  logic               cfg_is3_q, cfg_is3_d;
  logic [PIX_W-1:0]   num_pix_q, num_pix_d;
  logic [GRP_W-1:0]   groups_q, groups_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [GRP_W-1:0]   grp_q, grp_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [ADDR_W-1:0]  beat_q, beat_d;
  logic               rd1_q, lg1_q, vld_q, busy_q, done_q;
  logic [OP_W-1:0]    win_q, din_q;

  logic               rd_c, last_grp_c, last_pix_c;
  logic [GRP_W-1:0]   groups_c;
  logic [REM_W-1:0]   rem_c;
  logic [ELEM_NUM-1:0] mask_c;
  logic [OP_W-1:0]    win_c, din_c;

  // Read issue is combinational so hold takes effect in the same cycle.
  assign rd_c       = (state_q == S_RUN) && !hold;
  assign last_grp_c = (grp_q == GRP_W'(groups_q - GRP_W'(1)));
  assign last_pix_c = (pix_q == PIX_W'(num_pix_q - PIX_W'(1)));
  assign groups_c   = GRP_W'((32'(in_ch) + N - 1) / N);
  assign rem_c      = REM_W'(32'(in_ch) % N);

  // Next-state and counter logic.
  always_comb begin
    state_d     = state_q;
    cfg_in_ch_d = cfg_in_ch_q;
    cfg_is3_d   = cfg_is3_q;
    num_pix_d   = num_pix_q;
    groups_d    = groups_q;
    rem_d       = rem_q;
    grp_d       = grp_q;
    pix_d       = pix_q;
    beat_d      = beat_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cfg_in_ch_d = in_ch;
          cfg_is3_d   = is_conv3x3;
          num_pix_d   = num_pix;
          groups_d    = groups_c;
          rem_d       = rem_c;
          grp_d       = '0;
          pix_d       = '0;
          beat_d      = '0;
          state_d     = ((in_ch == '0) || (num_pix == '0)) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (rd_c) begin
          beat_d = beat_q + ADDR_W'(1);
          if (last_grp_c) begin
            grp_d = '0;
            pix_d = pix_q + PIX_W'(1);
            if (last_pix_c) state_d = S_DRAIN;
          end else begin
            grp_d = grp_q + GRP_W'(1);
          end
        end
      end
      // DRAIN plus DONE span the two pipeline cycles after the last read;
      // done is registered off DONE so it lands with the last beat + 1.
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  operand_mask u_mask (
    .is_conv3x3_i (cfg_is3_q),
    .last_grp_i   (lg1_q),
    .rem_i        (rem_q),
    .mask_c_o     (mask_c)
  );

  // One mask gates both operands of each element.
  always_comb begin
    win_c = '0;
    din_c = '0;
    for (int unsigned e = 0; e < ELEM_NUM; e++) begin
      if (mask_c[e]) begin
        win_c[e*WI +: WI] = bus.wbuf_data[e*WI +: WI];
        din_c[e*WI +: WI] = bus.dbuf_data[e*WI +: WI];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      cfg_in_ch_q <= '0;
      cfg_is3_q   <= 1'b0;
      num_pix_q   <= '0;
      groups_q    <= '0;
      rem_q       <= '0;
      grp_q       <= '0;
      pix_q       <= '0;
      beat_q      <= '0;
      rd1_q       <= 1'b0;
      lg1_q       <= 1'b0;
      vld_q       <= 1'b0;
      win_q       <= '0;
      din_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_in_ch_q <= cfg_in_ch_d;
      cfg_is3_q   <= cfg_is3_d;
      num_pix_q   <= num_pix_d;
      groups_q    <= groups_d;
      rem_q       <= rem_d;
      grp_q       <= grp_d;
      pix_q       <= pix_d;
      beat_q      <= beat_d;
      // Last-group flag rides with the read so masking never sees live counters.
      rd1_q       <= rd_c;
      if (rd_c) lg1_q <= last_grp_c;
      vld_q       <= rd1_q;
      if (rd1_q) begin
        win_q <= win_c;
        din_q <= din_c;
      end
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_q == S_DONE);
    end
  end

  assign bus.wbuf_rd        = rd_c;
  assign bus.dbuf_rd        = rd_c;
  assign bus.wbuf_addr      = ADDR_W'(grp_q);
  assign bus.dbuf_addr      = beat_q;
  assign bus.cfg_in_ch      = cfg_in_ch_q;
  assign bus.cfg_is_conv3x3 = cfg_is3_q;
  assign bus.vld_o          = vld_q;
  assign bus.win_o          = win_q;
  assign bus.din_o          = din_q;
  assign busy               = busy_q;
  assign done               = done_q;

endmodule

// File: tb/tb_conv_feeder.sv
// Directed bench for conv_feeder: buffer model, event log, per-layer checks.
module tb_conv_feeder;
  import conv_pkg::*;

  logic             clk = 1'b0;
  logic             rstn, start, is_conv3x3, hold, busy, done;
  logic [CH_W-1:0]  in_ch;
  logic [PIX_W-1:0] num_pix;

  conv_feeder_if bus ();

  conv_feeder dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .in_ch      (in_ch),
    .is_conv3x3 (is_conv3x3),
    .num_pix    (num_pix),
    .hold       (hold),
    .bus        (bus),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;
  int t0    = 0;
  bit ff_mode = 1'b0;

  int              rd_l[$];
  logic [11:0]     wa_l[$];
  logic [11:0]     da_l[$];
  int              vld_l[$];
  logic [OP_W-1:0] win_l[$];
  logic [OP_W-1:0] din_l[$];
  int              done_l[$];
  int              rd_diff;
  logic            busy_at [0:63];
  logic [7:0]      cfg_at  [0:63];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] welem(input int a, input int e);
    return ff_mode ? 8'hFF : 8'(e + 3 * a + 1);
  endfunction

  function automatic logic [7:0] delem(input int a, input int e);
    return ff_mode ? 8'hFF : 8'(255 - e - 5 * a);
  endfunction

  // Buffer model: registered read, data valid the cycle after rd.
  always @(posedge clk) begin
    if (bus.wbuf_rd)
      for (int e = 0; e < int'(ELEM_NUM); e++) bus.wbuf_data[e*WI +: WI] <= welem(int'(bus.wbuf_addr), e);
    if (bus.dbuf_rd)
      for (int e = 0; e < int'(ELEM_NUM); e++) bus.dbuf_data[e*WI +: WI] <= delem(int'(bus.dbuf_addr), e);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Event log, sampled mid-cycle; times are relative to the start cycle.
  always @(negedge clk) begin
    int r;
    r = cyc - t0;
    if (bus.wbuf_rd) begin
      rd_l.push_back(r);
      wa_l.push_back(bus.wbuf_addr);
      da_l.push_back(bus.dbuf_addr);
    end
    if (bus.wbuf_rd !== bus.dbuf_rd) rd_diff++;
    if (bus.vld_o) begin
      vld_l.push_back(r);
      win_l.push_back(bus.win_o);
      din_l.push_back(bus.din_o);
    end
    if (done) done_l.push_back(r);
    if (r >= 0 && r < 64) begin
      busy_at[r] = busy;
      cfg_at[r]  = bus.cfg_in_ch;
    end
  end

  task automatic clear_log();
    rd_l.delete(); wa_l.delete(); da_l.delete();
    vld_l.delete(); win_l.delete(); din_l.delete(); done_l.delete();
    rd_diff = 0;
    for (int i = 0; i < 64; i++) begin busy_at[i] = 1'b0; cfg_at[i] = 8'h0; end
  endtask

  // Launch one layer, optionally hold for cycles h0..h1 and re-pulse start
  // with different config in cycle rs_at, then check the logged events.
  task automatic run_layer(input string nm, input int ich, input bit is3, input int np,
                           input int h0, input int h1, input int rs_at,
                           input int exp_done, input int exp_beats);
    int grps, rem, k_exp;
    logic [127:0] ew, ed;
    @(posedge clk); #1;
    clear_log();
    t0 = cyc;
    in_ch = 8'(ich); is_conv3x3 = is3; num_pix = 16'(np); start = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      hold  = (k >= h0) && (k <= h1);
      if (k == rs_at) begin
        start = 1'b1; in_ch = 8'd64; num_pix = 16'd5; is_conv3x3 = !is3;
      end
      if (done_l.size() > 0 && k >= done_l[0] + 3) break;
    end
    hold = 1'b0; start = 1'b0;
    grps = (ich + 15) / 16;
    rem  = ich % 16;
    check_eq({nm, ".done_cnt"}, 128'(done_l.size()), 128'(1));
    if (done_l.size() == 1) check_eq({nm, ".done_cyc"}, 128'(done_l[0]), 128'(exp_done));
    check_eq({nm, ".reads"}, 128'(rd_l.size()), 128'(exp_beats));
    check_eq({nm, ".beats"}, 128'(vld_l.size()), 128'(exp_beats));
    check_eq({nm, ".rd_same"}, 128'(rd_diff), 128'(0));
    check_eq({nm, ".busy1"}, 128'(busy_at[1]), 128'(1));
    check_eq({nm, ".busy_end"}, 128'(busy_at[exp_done - 1]), 128'(1));
    check_eq({nm, ".busy_off"}, 128'(busy_at[exp_done]), 128'(0));
    check_eq({nm, ".cfg_in_ch"}, 128'(cfg_at[exp_done - 1]), 128'(ich));
    k_exp = 1;
    for (int j = 0; j < exp_beats && j < rd_l.size() && j < vld_l.size(); j++) begin
      while (k_exp >= h0 && k_exp <= h1) k_exp++;
      check_eq($sformatf("%s.rd_cyc%0d", nm, j), 128'(rd_l[j]), 128'(k_exp));
      check_eq($sformatf("%s.vld_cyc%0d", nm, j), 128'(vld_l[j]), 128'(k_exp + 2));
      check_eq($sformatf("%s.waddr%0d", nm, j), 128'(wa_l[j]), 128'(j % grps));
      check_eq($sformatf("%s.daddr%0d", nm, j), 128'(da_l[j]), 128'(j));
      k_exp++;
      for (int t = 0; t < int'(MAC_NUM); t++) begin
        for (int c = 0; c < int'(N); c++) begin
          bit keep;
          keep = (is3 || t == 0) && !(((j % grps) == grps - 1) && rem != 0 && c >= rem);
          ew[c*WI +: WI] = keep ? welem(j % grps, t * 16 + c) : 8'h00;
          ed[c*WI +: WI] = keep ? delem(j, t * 16 + c) : 8'h00;
        end
        check_eq($sformatf("%s.win%0d.t%0d", nm, j, t), win_l[j][t*TAP_W +: TAP_W], ew);
        check_eq($sformatf("%s.din%0d.t%0d", nm, j, t), din_l[j][t*TAP_W +: TAP_W], ed);
      end
    end
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; hold = 1'b0; in_ch = '0; is_conv3x3 = 1'b0; num_pix = '0;
    bus.wbuf_data = '0; bus.dbuf_data = '0;
    clear_log();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst.vld",  128'(bus.vld_o), 128'(0));
    check_eq("rst.busy", 128'(busy), 128'(0));
    check_eq("rst.done", 128'(done), 128'(0));
    check_eq("rst.rd",   128'(bus.wbuf_rd), 128'(0));
    check_eq("rst.cfg",  128'({bus.cfg_is_conv3x3, bus.cfg_in_ch}), 128'(0));
    check_eq("rst.data", 128'({|bus.win_o, |bus.din_o}), 128'(0));
    check_eq("rst.addr", 128'({bus.wbuf_addr, bus.dbuf_addr}), 128'(0));
    @(posedge clk); #1 rstn = 1'b1;

    run_layer("l32",  32, 1'b1, 3, 100, 0, -1, 9, 6);
    ff_mode = 1'b1;
    run_layer("l16_1x1", 16, 1'b0, 2, 100, 0, -1, 5, 2);
    ff_mode = 1'b0;
    run_layer("l20",  20, 1'b1, 1, 100, 0, -1, 5, 2);
    run_layer("hold", 32, 1'b1, 2, 2, 3, -1, 9, 4);
    run_layer("ch0",   0, 1'b1, 4, 100, 0, -1, 2, 0);
    run_layer("pix0", 32, 1'b1, 0, 100, 0, -1, 2, 0);
    run_layer("restart", 32, 1'b1, 1, 100, 0, 1, 5, 2);

    // Reset in cycle 4 of a 6-beat layer.
    @(posedge clk); #1;
    clear_log();
    t0 = cyc; in_ch = 8'd32; is_conv3x3 = 1'b1; num_pix = 16'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check_eq("mid_rst.vld",  128'(bus.vld_o), 128'(0));
    check_eq("mid_rst.busy", 128'(busy), 128'(0));
    check_eq("mid_rst.rd",   128'(bus.wbuf_rd), 128'(0));
    check_eq("mid_rst.cfg",  128'({bus.cfg_is_conv3x3, bus.cfg_in_ch}), 128'(0));
    check_eq("mid_rst.data", 128'({|bus.win_o, |bus.din_o}), 128'(0));
    check_eq("mid_rst.addr", 128'({bus.wbuf_addr, bus.dbuf_addr}), 128'(0));
    vld_l.delete(); done_l.delete(); rd_l.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check_eq("post_rst.vld",  128'(vld_l.size()), 128'(0));
    check_eq("post_rst.rd",   128'(rd_l.size()), 128'(0));
    check_eq("post_rst.done", 128'(done_l.size()), 128'(0));
    check_eq("post_rst.busy", 128'(busy), 128'(0));
    run_layer("after_rst", 32, 1'b1, 3, 100, 0, -1, 9, 6);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
